// File: rtl/dm_responder_pkg.sv
// Shared CPU-side definitions for the data-memory responder.
//   dm_state_e : responder FSM state encoding
//   DM_LATENCY : default request-to-completion latency in cycles
//   DM_DEPTH   : default storage depth in 32-bit words
package dm_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dm_state_e;

    localparam int DM_LATENCY = 2;
    localparam int DM_DEPTH   = 1024;

endpackage

// File: rtl/dm_bank.sv
// Word-addressed storage with byte-lane writes and a registered read port.
//   clk, rst  : clock; rst clears only the read register, never the array
//   we_i      : write strobe, lanes selected by be_i
//   re_i      : capture mem[idx_i] into the read register
//   clr_i     : load zero into the read register (misaligned load)
//   idx_i     : word index
//   wdata_i   : write data
//   be_i      : byte-lane enables
//   rdata_o   : registered read data
module dm_bank
    import dm_responder_pkg::*;
#(
    parameter int DEPTH = DM_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we_i,
    input  logic                     re_i,
    input  logic                     clr_i,
    input  logic [$clog2(DEPTH)-1:0] idx_i,
    input  logic [31:0]              wdata_i,
    input  logic [3:0]               be_i,
    output logic [31:0]              rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        rdata_q <= '0;
        else if (clr_i) rdata_q <= '0;
        else if (re_i)  rdata_q <= mem_q[idx_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder for a CPU MEM stage. One access at a
// time: the request is latched in IDLE, held through BUSY, and completed in
// DONE with a one-cycle rvalid pulse; stall holds the pipeline meanwhile.
//   clk, rst          : clock, asynchronous active-high reset
//   MemRead, MemWrite : load / store request (both set means store)
//   addr              : byte address, word index addr[11:2] modulo DEPTH
//   din, be           : store data and byte-lane enables
//   dout              : registered load data, held until the next load
//   rvalid            : completion pulse
//   stall             : combinational hold request
//   err               : misaligned-access pulse, coincident with rvalid
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int LATENCY = DM_LATENCY,
    parameter int DEPTH   = DM_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic [3:0]  be,
    output logic [31:0] dout,
    output logic        rvalid,
    output logic        stall,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);

    dm_state_e   state_q;
    logic [3:0]  cnt_q;
    logic [11:0] addr_q;
    logic [31:0] din_q;
    logic [3:0]  be_q;
    logic        wr_q;
    logic        rvalid_q, err_q;

    logic          req, in_idle, finish_d, wr_d, mis_d;
    logic [11:0]   addr_d;
    logic [31:0]   din_d;
    logic [3:0]    be_d;
    logic [AW-1:0] idx_d;
    logic          unused_addr_hi;

    assign req     = MemRead | MemWrite;
    assign in_idle = (state_q == IDLE);

    // The access completes on the edge that enters DONE. With LATENCY=1 that
    // is the edge ending the request cycle itself, so the live inputs are the
    // request; otherwise the latched copy is used and input changes are ignored.
    // cnt_q counts BUSY cycles still to run, including the current one.
    assign finish_d = (in_idle && req && LATENCY == 1) ||
                      (state_q == BUSY && cnt_q <= 4'd1);

    assign wr_d   = in_idle ? MemWrite    : wr_q;
    assign addr_d = in_idle ? addr[11:0]  : addr_q;
    assign din_d  = in_idle ? din         : din_q;
    assign be_d   = in_idle ? be          : be_q;
    assign mis_d  = (addr_d[1:0] != 2'b00);
    assign idx_d  = AW'({22'd0, addr_d[11:2]} % 32'(DEPTH));

    assign unused_addr_hi = ^addr[31:12];

    assign stall = (in_idle && req) || (state_q == BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            be_q     <= '0;
            wr_q     <= 1'b0;
        end else begin
            rvalid_q <= finish_d;
            err_q    <= finish_d & mis_d;
            case (state_q)
                IDLE: if (req) begin
                    addr_q  <= addr[11:0];
                    din_q   <= din;
                    be_q    <= be;
                    wr_q    <= MemWrite;
                    cnt_q   <= 4'(LATENCY - 1);
                    state_q <= (LATENCY == 1) ? DONE : BUSY;
                end
                BUSY: if (finish_d) begin
                    cnt_q   <= '0;
                    state_q <= DONE;
                end else begin
                    cnt_q   <= cnt_q - 4'd1;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    dm_bank #(.DEPTH(DEPTH)) u_bank (
        .clk     (clk),
        .rst     (rst),
        .we_i    (finish_d & wr_d & ~mis_d),
        .re_i    (finish_d & ~wr_d & ~mis_d),
        .clr_i   (finish_d & ~wr_d & mis_d),
        .idx_i   (idx_d),
        .wdata_i (din_d),
        .be_i    (be_d),
        .rdata_o (dout)
    );

    assign rvalid = rvalid_q;
    assign err    = err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Randomized scoreboard bench for dm_responder: a word-array reference model
// predicts each completion (cycle, dout, err); a negedge monitor compares.
module tb_dm_responder;

    localparam int L = 2;
    localparam int D = 256;   // smaller than 1024 so addr[11:2] wraps

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemRead = 1'b0, MemWrite = 1'b0;
    logic [31:0] addr = '0, din = '0;
    logic [3:0]  be = '0;
    logic [31:0] dout;
    logic        rvalid, stall, err;

    logic        r1 = 1'b0, w1 = 1'b0;
    logic [31:0] a1 = '0, d1 = '0;
    logic [3:0]  b1 = '0;
    logic [31:0] dout1;
    logic        rvalid1, stall1, err1;

    always #5 clk = ~clk;

    dm_responder #(.LATENCY(L), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .addr(addr), .din(din), .be(be), .dout(dout), .rvalid(rvalid),
        .stall(stall), .err(err)
    );

    dm_responder #(.LATENCY(1), .DEPTH(1024)) dut1 (
        .clk(clk), .rst(rst), .MemRead(r1), .MemWrite(w1),
        .addr(a1), .din(d1), .be(b1), .dout(dout1), .rvalid(rvalid1),
        .stall(stall1), .err(err1)
    );

    typedef struct {
        int          cyc;
        logic [31:0] dout;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem_m [D];
    logic [31:0] dout_m = '0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: a plain word array; stores update selected bytes, loads
    // replace the held read value, misaligned accesses do neither (loads read 0).
    task automatic model(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, output exp_t e);
        int   idx;
        logic mis;
        idx = int'(a[11:2]) % D;
        mis = (a[1:0] != 2'b00);
        if (wr) begin
            if (!mis)
                for (int i = 0; i < 4; i++)
                    if (b[i]) mem_m[idx][8*i +: 8] = d[8*i +: 8];
        end else begin
            dout_m = mis ? 32'd0 : mem_m[idx];
        end
        e.dout = dout_m;
        e.err  = mis;
        e.cyc  = cyc + L;
    endtask

    // Called just after a rising edge with the DUT in IDLE. Scrambles inputs
    // during BUSY, optionally re-presents the request during DONE.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b, input bit hold_done);
        exp_t e;
        MemRead = rd; MemWrite = wr; addr = a; din = d; be = b;
        model(wr, a, d, b, e);
        sb.push_back(e);
        for (int k = 0; k <= L; k++) begin
            @(negedge clk);
            chk("stall", 32'(stall), 32'(k < L));
            @(posedge clk); #1;
            if (k < L - 1) begin
                MemRead = 1'($urandom); MemWrite = 1'($urandom);
                addr = $urandom; din = $urandom; be = 4'($urandom);
            end else if (k == L - 1) begin
                if (hold_done) begin
                    MemRead = rd; MemWrite = wr; addr = a; din = d; be = b;
                end else begin
                    MemRead = 1'b0; MemWrite = 1'b0;
                end
            end
        end
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && rvalid) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL spurious_rvalid got=1 expected=0 (cyc %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("rvalid_cycle", 32'(cyc), 32'(e.cyc));
                chk("dout", dout, e.dout);
                chk("err", 32'(err), 32'(e.err));
            end
        end else if (!rst && err) begin
            checks++; failures++;
            $display("FAIL err_without_rvalid got=1 expected=0 (cyc %0d)", cyc);
        end
    end

    initial begin
        logic        rd, wr;
        logic [31:0] a;

        // Reset values, and stall following the request while held in reset.
        #3;
        chk("rst_dout", dout, 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_stall_idle", 32'(stall), 32'd0);
        MemRead = 1'b1; r1 = 1'b1;
        #1;
        chk("rst_stall_req", 32'(stall), 32'd1);
        chk("rst_stall_req_l1", 32'(stall1), 32'd1);
        MemRead = 1'b0; r1 = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Fill every word so later loads have a defined value.
        for (int i = 0; i < D; i++) issue(1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0);

        // Directed cases.
        issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        issue(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
        issue(1'b0, 1'b1, 32'h10, 32'h0000AA00, 4'b0010, 1'b0);
        issue(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);          // DEADAAEF
        issue(1'b0, 1'b1, 32'h13, 32'h11223344, 4'hF, 1'b0);   // err, no write
        issue(1'b1, 1'b0, 32'h12, 32'h0, 4'hF, 1'b0);          // dout 0, err
        issue(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
        issue(1'b1, 1'b1, 32'h20, 32'h5, 4'hF, 1'b1);          // treated as store
        issue(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
        issue(1'b0, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 1'b0);  // wraps to word 0
        issue(1'b1, 1'b0, 32'h000, 32'h0, 4'h0, 1'b0);
        issue(1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'h0, 1'b0);   // be=0: no write
        issue(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            rd = 1'($urandom); wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            a = 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            issue(rd, wr, a, $urandom, 4'($urandom), 1'($urandom));
        end

        // LATENCY=1 instance: stall only in the request cycle, rvalid next.
        r1 = 1'b0; w1 = 1'b1; a1 = 32'h40; d1 = 32'hA5A55A5A; b1 = 4'hF;
        @(negedge clk);
        chk("l1_st_stall", 32'(stall1), 32'd1);
        chk("l1_st_rvalid_early", 32'(rvalid1), 32'd0);
        @(negedge clk);
        chk("l1_st_rvalid", 32'(rvalid1), 32'd1);
        chk("l1_st_stall_done", 32'(stall1), 32'd0);
        @(posedge clk); #1;
        r1 = 1'b1; w1 = 1'b0; a1 = 32'h40;
        @(negedge clk);
        chk("l1_ld_stall", 32'(stall1), 32'd1);
        @(negedge clk);
        chk("l1_ld_rvalid", 32'(rvalid1), 32'd1);
        chk("l1_ld_dout", dout1, 32'hA5A55A5A);
        chk("l1_ld_err", 32'(err1), 32'd0);
        @(posedge clk); #1;
        r1 = 1'b0;

        // Reset in BUSY of a store: outputs clear at once, store is dropped.
        issue(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        MemWrite = 1'b1; addr = 32'h30; din = 32'h12345678; be = 4'hF;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("abort_dout", dout, 32'd0);
        chk("abort_rvalid", 32'(rvalid), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        chk("abort_stall_req", 32'(stall), 32'd1);
        dout_m = '0;
        MemWrite = 1'b0;
        #1;
        chk("abort_stall_idle", 32'(stall), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        issue(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0);
        issue(1'b0, 1'b1, 32'h30, 32'h0BADF00D, 4'hF, 1'b0);
        issue(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
